// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg -- shared definitions for the pipeline hazard unit.
// Holds the mul/div tracker state encodings, the ALU forward-select codes,
// the default mul/div latency and small register-compare helpers used by
// hazard_unit and md_tracker.
package hazard_unit_pkg;

  // mul/div tracker states
  localparam logic [0:0] MD_IDLE = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

  // ALU operand forward-select codes
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // cycles the mul/div unit stays busy after issue
  localparam int MD_LATENCY_DEFAULT = 32;

  // width of the mul/div down-counter
  localparam int MD_CNT_W = 6;

  // Register numbers match only when nonzero; $0 is hard-wired and never
  // produces a real dependency.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

  // ALU operand select: the MEM result is younger than WB, so it wins.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] wr_mem,
                                         input logic       rw_mem,
                                         input logic [4:0] wr_wb,
                                         input logic       rw_wb);
    logic [1:0] sel;
    if (rw_mem && reg_match(src, wr_mem)) begin
      sel = FWD_MEM;
    end else if (rw_wb && reg_match(src, wr_wb)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_unit_md_tracker.sv
// md_tracker -- occupancy tracker for the multi-cycle mul/div unit.
// Ports:
//   clk    in  rising-edge clock
//   rst    in  synchronous active-high reset (aborts a running operation)
//   start  in  mul/div issued from EXE this cycle
//   busy   out unit occupied; high for MD_LATENCY cycles starting the
//              cycle after issue
//   done   out one-cycle pulse in the last busy cycle (HI/LO valid)
module md_tracker
  import hazard_unit_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam logic [MD_CNT_W-1:0] CNT_LOAD = MD_CNT_W'(MD_LATENCY - 1);

  logic [0:0]          state_d, state_q;
  logic [MD_CNT_W-1:0] cnt_d, cnt_q;
  logic                done_d, done_q;

  // Next-state and counter logic; a start while BUSY is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_BUSY: begin
        if (cnt_q == {MD_CNT_W{1'b0}}) begin
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - MD_CNT_W'(1);
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = {MD_CNT_W{1'b0}};
      end
    endcase
    // done is registered: it rises in the cycle where the counter sits at
    // zero in BUSY, so look one state ahead.
    done_d = (state_d == MD_BUSY) && (cnt_d == {MD_CNT_W{1'b0}});
  end

  // State, counter and done flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= {MD_CNT_W{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == MD_BUSY);
  assign done = done_q;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit -- stall, flush and forwarding control for a 5-stage MIPS
// pipeline with branches resolved in decode and a multi-cycle mul/div unit.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   *_decode inputs                 decode-stage sources and instruction kind
//   *_exe / *_mem / *_wb inputs     later-stage sources, destinations, enables
//   stall_fetch, stall_decode       hold PC and IF/ID
//   flush_decode                    clear IF/ID on a taken branch/jump
//   flush_exe                       bubble into ID/EXE while decode stalls
//   forwardA/B_decode               branch comparator takes the MEM result
//   forwardA/B_exe                  ALU operand select (RF / WB / MEM)
//   md_busy, md_done                mul/div occupancy and completion pulse
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs_decode,
  input  logic [4:0] Rt_decode,
  input  logic       branch_decode,
  input  logic       pcsrc_decode,
  input  logic       muldiv_start_decode,
  input  logic       hilo_read_decode,
  input  logic [4:0] Rs_exe,
  input  logic [4:0] Rt_exe,
  input  logic [4:0] writereg_exe,
  input  logic [4:0] writereg_mem,
  input  logic [4:0] writereg_wb,
  input  logic       regwrite_exe,
  input  logic       regwrite_mem,
  input  logic       regwrite_wb,
  input  logic       memtoreg_exe,
  input  logic       memtoreg_mem,
  input  logic       muldiv_start_exe,
  output logic       stall_fetch,
  output logic       stall_decode,
  output logic       flush_decode,
  output logic       flush_exe,
  output logic       forwardA_decode,
  output logic       forwardB_decode,
  output logic [1:0] forwardA_exe,
  output logic [1:0] forwardB_exe,
  output logic       md_busy,
  output logic       md_done
);

  logic lwstall_s;
  logic brstall_s;
  logic mdstall_s;
  logic stall_s;

  md_tracker #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_tracker (
    .clk  (clk),
    .rst  (rst),
    .start(muldiv_start_exe),
    .busy (md_busy),
    .done (md_done)
  );

  // Stall, flush and forward decisions; purely combinational.
  always_comb begin
    forwardA_exe = fwd_sel(Rs_exe, writereg_mem, regwrite_mem, writereg_wb, regwrite_wb);
    forwardB_exe = fwd_sel(Rt_exe, writereg_mem, regwrite_mem, writereg_wb, regwrite_wb);

    forwardA_decode = regwrite_mem && reg_match(Rs_decode, writereg_mem);
    forwardB_decode = regwrite_mem && reg_match(Rt_decode, writereg_mem);

    // load-use: the loaded value is not available until after MEM
    lwstall_s = memtoreg_exe &&
                (reg_match(Rs_decode, writereg_exe) || reg_match(Rt_decode, writereg_exe));

    // Branch compares in decode: an ALU result still in EXE, or a load
    // still in MEM, cannot be forwarded to the comparator in time.
    brstall_s = branch_decode &&
                ((regwrite_exe &&
                  (reg_match(Rs_decode, writereg_exe) || reg_match(Rt_decode, writereg_exe))) ||
                 (memtoreg_mem &&
                  (reg_match(Rs_decode, writereg_mem) || reg_match(Rt_decode, writereg_mem))));

    // The issue cycle counts as occupied, since the tracker turns busy
    // only on the following cycle.
    mdstall_s = (muldiv_start_decode || hilo_read_decode) &&
                (md_busy || muldiv_start_exe);

    stall_s = lwstall_s || brstall_s || mdstall_s;

    stall_fetch  = stall_s;
    stall_decode = stall_s;
    flush_exe    = stall_s;
    // a stalled branch has not resolved yet, so it must not flush IF/ID
    flush_decode = pcsrc_decode && !stall_s;
  end

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  logic       clk;
  logic       rst;
  logic [4:0] Rs_decode, Rt_decode, Rs_exe, Rt_exe;
  logic [4:0] writereg_exe, writereg_mem, writereg_wb;
  logic       branch_decode, pcsrc_decode, muldiv_start_decode, hilo_read_decode;
  logic       regwrite_exe, regwrite_mem, regwrite_wb;
  logic       memtoreg_exe, memtoreg_mem, muldiv_start_exe;
  logic       stall_fetch, stall_decode, flush_decode, flush_exe;
  logic       forwardA_decode, forwardB_decode;
  logic [1:0] forwardA_exe, forwardB_exe;
  logic       md_busy, md_done;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_unit #(.MD_LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .Rs_decode(Rs_decode), .Rt_decode(Rt_decode),
    .branch_decode(branch_decode), .pcsrc_decode(pcsrc_decode),
    .muldiv_start_decode(muldiv_start_decode), .hilo_read_decode(hilo_read_decode),
    .Rs_exe(Rs_exe), .Rt_exe(Rt_exe),
    .writereg_exe(writereg_exe), .writereg_mem(writereg_mem), .writereg_wb(writereg_wb),
    .regwrite_exe(regwrite_exe), .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb),
    .memtoreg_exe(memtoreg_exe), .memtoreg_mem(memtoreg_mem),
    .muldiv_start_exe(muldiv_start_exe),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .flush_decode(flush_decode), .flush_exe(flush_exe),
    .forwardA_decode(forwardA_decode), .forwardB_decode(forwardB_decode),
    .forwardA_exe(forwardA_exe), .forwardB_exe(forwardB_exe),
    .md_busy(md_busy), .md_done(md_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
    logic       br, pcsrc, mds_d, hilo_d, rw_e, rw_m, rw_w, mtr_e, mtr_m, start_e;
  } vec_t;

  typedef struct {
    string      tag;
    logic       stall, flush_d, fa_d, fb_d, busy, done;
    logic [1:0] fa_e, fb_e;
  } exp_t;

  vec_t tbl_in[$];
  exp_t tbl_exp[$];
  exp_t sb[$];

  task automatic drive(input vec_t v);
    Rs_decode = v.rs_d;  Rt_decode = v.rt_d;  Rs_exe = v.rs_e;  Rt_exe = v.rt_e;
    writereg_exe = v.wr_e;  writereg_mem = v.wr_m;  writereg_wb = v.wr_w;
    branch_decode = v.br;  pcsrc_decode = v.pcsrc;
    muldiv_start_decode = v.mds_d;  hilo_read_decode = v.hilo_d;
    regwrite_exe = v.rw_e;  regwrite_mem = v.rw_m;  regwrite_wb = v.rw_w;
    memtoreg_exe = v.mtr_e;  memtoreg_mem = v.mtr_m;  muldiv_start_exe = v.start_e;
  endtask

  task automatic chk(input string tag, input string what, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0h required=%0h", tag, what, act, req);
    end
  endtask

  // pop the oldest expectation and compare against the DUT outputs now
  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = sb.pop_front();
      chk(e.tag, "stall_fetch",  {7'd0, stall_fetch},  {7'd0, e.stall});
      chk(e.tag, "stall_decode", {7'd0, stall_decode}, {7'd0, e.stall});
      chk(e.tag, "flush_exe",    {7'd0, flush_exe},    {7'd0, e.stall});
      chk(e.tag, "flush_decode", {7'd0, flush_decode}, {7'd0, e.flush_d});
      chk(e.tag, "fwdA_decode",  {7'd0, forwardA_decode}, {7'd0, e.fa_d});
      chk(e.tag, "fwdB_decode",  {7'd0, forwardB_decode}, {7'd0, e.fb_d});
      chk(e.tag, "fwdA_exe",     {6'd0, forwardA_exe}, {6'd0, e.fa_e});
      chk(e.tag, "fwdB_exe",     {6'd0, forwardB_exe}, {6'd0, e.fb_e});
      chk(e.tag, "md_busy",      {7'd0, md_busy},      {7'd0, e.busy});
      chk(e.tag, "md_done",      {7'd0, md_done},      {7'd0, e.done});
    end
  endtask

  function automatic exp_t mk_exp(input string tag, input logic stall, input logic flush_d,
                                  input logic fa_d, input logic fb_d, input logic [1:0] fa_e,
                                  input logic [1:0] fb_e, input logic busy, input logic done);
    exp_t e;
    e.tag = tag; e.stall = stall; e.flush_d = flush_d; e.fa_d = fa_d; e.fb_d = fb_d;
    e.fa_e = fa_e; e.fb_e = fb_e; e.busy = busy; e.done = done;
    return e;
  endfunction

  // one cycle: drive after the edge, record expectation, sample mid-cycle
  task automatic step(input vec_t v, input logic r, input exp_t e);
    @(posedge clk); #1;
    drive(v);
    rst = r;
    sb.push_back(e);
    @(negedge clk);
    pop_compare();
  endtask

  // mul/div scenario: expected busy/done/stall per cycle offset after issue
  task automatic md_seq(input string tag, input int rst_off, input int restart_off);
    vec_t v;
    logic eb, ed, es, r;
    bit   aborted;
    aborted = 1'b0;
    for (int off = 0; off < 8; off++) begin
      v = '{default: '0};
      v.start_e = (off == 0) || (off == restart_off);
      v.hilo_d  = (restart_off < 0) && (off <= 5);
      r = (off == rst_off);
      if (off > rst_off && rst_off >= 0) aborted = 1'b1;
      eb = !aborted && (off >= 1) && (off <= 4);
      ed = !aborted && (off == 4);
      es = v.hilo_d && (eb || v.start_e);
      step(v, r, mk_exp($sformatf("%s_c%0d", tag, off), es, 1'b0, 1'b0, 1'b0,
                        2'b00, 2'b00, eb, ed));
    end
  endtask

  initial begin
    vec_t v;
    v = '{default: '0};
    drive(v);
    rst = 1'b1;

    // reset state (rst held high through the sample)
    repeat (2) @(posedge clk);
    step(v, 1'b1, mk_exp("reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
    step(v, 1'b0, mk_exp("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0));

    // combinational vector table
    v = '{default: '0};
    tbl_in.push_back(v);
    tbl_exp.push_back(mk_exp("idle", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    v = '{default: '0}; v.mtr_e = 1; v.rw_e = 1; v.wr_e = 5'd8; v.rs_d = 5'd8;
    tbl_in.push_back(v);
    tbl_exp.push_back(mk_exp("lw_rs", 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    v = '{default: '0}; v.mtr_e = 1; v.rw_e = 1; v.wr_e = 5'd8; v.rt_d = 5'd8; v.rs_d = 5'd9;
    tbl_in.push_back(v);
    tbl_exp.push_back(mk_exp("lw_rt", 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    v = '{default: '0}; v.mtr_e = 1; v.rw_e = 1; v.wr_e = 5'd0; v.rs_d = 5'd0;
    tbl_in.push_back(v);
    tbl_exp.push_back(mk_exp("lw_zero", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    v = '{default: '0}; v.rs_e = 5'd5; v.wr_m = 5'd5; v.rw_m = 1; v.wr_w = 5'd5; v.rw_w = 1;
    tbl_in.push_back(v);
    tbl_exp.push_back(mk_exp("fwdA_mem", 0, 0, 0, 0, 2'b10, 2'b00, 0, 0));
    v.rw_m = 0;
    tbl_in.push_back(v);
    tbl_exp.push_back(mk_exp("fwdA_wb", 0, 0, 0, 0, 2'b01, 2'b00, 0, 0));
    v.rw_m = 1; v.rs_e = 5'd0;
    tbl_in.push_back(v);
    tbl_exp.push_back(mk_exp("fwdA_r0", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    v = '{default: '0}; v.rt_e = 5'd7; v.wr_m = 5'd7; v.rw_m = 1;
    tbl_in.push_back(v);
    tbl_exp.push_back(mk_exp("fwdB_mem", 0, 0, 0, 0, 2'b00, 2'b10, 0, 0));
    v = '{default: '0}; v.rt_e = 5'd9; v.wr_m = 5'd9; v.wr_w = 5'd9; v.rw_w = 1;
    tbl_in.push_back(v);
    tbl_exp.push_back(mk_exp("fwdB_wb", 0, 0, 0, 0, 2'b00, 2'b01, 0, 0));
    v = '{default: '0}; v.br = 1; v.pcsrc = 1; v.rt_d = 5'd3; v.rw_e = 1; v.wr_e = 5'd3;
    tbl_in.push_back(v);
    tbl_exp.push_back(mk_exp("br_exe", 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    v = '{default: '0}; v.br = 1; v.pcsrc = 1; v.rs_d = 5'd2; v.rt_d = 5'd3; v.rw_e = 1; v.wr_e = 5'd4;
    tbl_in.push_back(v);
    tbl_exp.push_back(mk_exp("br_taken", 0, 1, 0, 0, 2'b00, 2'b00, 0, 0));
    v = '{default: '0}; v.br = 1; v.rs_d = 5'd6; v.wr_m = 5'd6; v.mtr_m = 1; v.rw_m = 1;
    tbl_in.push_back(v);
    tbl_exp.push_back(mk_exp("br_ldmem", 1, 0, 1, 0, 2'b00, 2'b00, 0, 0));
    v = '{default: '0}; v.br = 1; v.rs_d = 5'd6; v.rt_d = 5'd6; v.wr_m = 5'd6; v.rw_m = 1;
    tbl_in.push_back(v);
    tbl_exp.push_back(mk_exp("br_fwd", 0, 0, 1, 1, 2'b00, 2'b00, 0, 0));
    v = '{default: '0}; v.rs_d = 5'd3; v.rw_e = 1; v.wr_e = 5'd3;
    tbl_in.push_back(v);
    tbl_exp.push_back(mk_exp("alu_nobr", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    v = '{default: '0}; v.hilo_d = 1; v.mds_d = 1;
    tbl_in.push_back(v);
    tbl_exp.push_back(mk_exp("md_idle", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    v = '{default: '0}; v.rt_d = 5'd4; v.wr_m = 5'd4; v.rw_m = 0; v.pcsrc = 1;
    tbl_in.push_back(v);
    tbl_exp.push_back(mk_exp("nofwd_rw0", 0, 1, 0, 0, 2'b00, 2'b00, 0, 0));

    for (int i = 0; i < tbl_in.size(); i++) begin
      step(tbl_in[i], 1'b0, tbl_exp[i]);
    end

    // multi-cycle mul/div corner cases
    md_seq("md_lat", -1, -1);
    md_seq("md_rst", 2, -1);
    md_seq("md_restart", -1, 2);

    // reset dominates a coincident issue
    v = '{default: '0}; v.start_e = 1;
    step(v, 1'b1, mk_exp("rst_dom_c0", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    v = '{default: '0};
    step(v, 1'b0, mk_exp("rst_dom_c1", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    step(v, 1'b0, mk_exp("rst_dom_c2", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));

    if (sb.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
